// File: rtl/regfile_write_arbiter.sv
// Single-port regfile write arbiter: CPU writeback has priority, three peripherals
// share the port through 1-entry buffers served round-robin with anti-starvation aging.
module regfile_write_arbiter (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_reg,
  input  logic [31:0] cpu_data,
  output logic        cpu_stall,
  input  logic        p0_valid,
  input  logic [4:0]  p0_reg,
  input  logic [31:0] p0_data,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_reg,
  input  logic [31:0] p1_data,
  output logic        p1_ready,
  input  logic        p2_valid,
  input  logic [4:0]  p2_reg,
  input  logic [31:0] p2_data,
  output logic        p2_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        pending
);

  localparam int unsigned NP = 3;

  logic [NP-1:0] full_q, full_d;
  logic [4:0]    breg_q  [NP];
  logic [4:0]    breg_d  [NP];
  logic [31:0]   bdata_q [NP];
  logic [31:0]   bdata_d [NP];
  logic [2:0]    age_q   [NP];
  logic [2:0]    age_d   [NP];
  logic [1:0]    last_q, last_d;
  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [NP-1:0] p_valid;
  logic [4:0]    p_reg  [NP];
  logic [31:0]   p_data [NP];

  logic          stall;
  logic          rr_found;
  logic [1:0]    rr_idx;
  logic          cpu_grant;
  logic          per_grant;

  assign p_valid   = {p2_valid, p1_valid, p0_valid};
  assign p_reg[0]  = p0_reg;
  assign p_reg[1]  = p1_reg;
  assign p_reg[2]  = p2_reg;
  assign p_data[0] = p0_data;
  assign p_data[1] = p1_data;
  assign p_data[2] = p2_data;

  // (last + offset) mod 3 for last in 0..2 and offset in 1..3
  function automatic logic [1:0] rr_index(input logic [1:0] last, input logic [1:0] offset);
    logic [2:0] s;
    s = {1'b0, last} + {1'b0, offset};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (full_q[i] && (age_q[i] == 3'd7)) stall = 1'b1;
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = 2'd0;
    for (int k = 1; k <= NP; k++) begin
      if (!rr_found && full_q[rr_index(last_q, 2'(k))]) begin
        rr_found = 1'b1;
        rr_idx   = rr_index(last_q, 2'(k));
      end
    end
  end

  // A CPU write to r0 is dropped here, which lets a peripheral take the port instead.
  assign cpu_grant = !stall && cpu_we && (cpu_reg != 5'd0);
  assign per_grant = !cpu_grant && rr_found;

  always_comb begin
    full_d  = full_q;
    breg_d  = breg_q;
    bdata_d = bdata_q;
    age_d   = age_q;
    last_d  = last_q;
    we_d    = cpu_grant || per_grant;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;

    if (cpu_grant) begin
      wreg_d  = cpu_reg;
      wdata_d = cpu_data;
    end else if (per_grant) begin
      wreg_d  = breg_q[rr_idx];
      wdata_d = bdata_q[rr_idx];
      last_d  = rr_idx;
    end

    for (int i = 0; i < NP; i++) begin
      if (per_grant && (rr_idx == 2'(i))) begin
        full_d[i] = 1'b0;
        age_d[i]  = 3'd0;
      end else if (full_q[i]) begin
        age_d[i] = (age_q[i] == 3'd7) ? 3'd7 : age_q[i] + 3'd1;
      end else begin
        age_d[i] = 3'd0;
        // Requests to r0 are handshaken (ready is high) but never buffered.
        if (p_valid[i] && (p_reg[i] != 5'd0)) begin
          full_d[i]  = 1'b1;
          breg_d[i]  = p_reg[i];
          bdata_d[i] = p_data[i];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      full_q  <= '0;
      last_q  <= 2'd2;
      we_q    <= 1'b0;
      wreg_q  <= 5'd0;
      wdata_q <= 32'd0;
      for (int i = 0; i < NP; i++) begin
        breg_q[i]  <= 5'd0;
        bdata_q[i] <= 32'd0;
        age_q[i]   <= 3'd0;
      end
    end else begin
      full_q  <= full_d;
      breg_q  <= breg_d;
      bdata_q <= bdata_d;
      age_q   <= age_d;
      last_q  <= last_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign cpu_stall        = stall;
  assign p0_ready         = ~full_q[0];
  assign p1_ready         = ~full_q[1];
  assign p2_ready         = ~full_q[2];
  assign pending          = |full_q;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for starvation, r0 filtering, ordering and mid-run reset.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        cpu_we;
  logic [4:0]  cpu_reg;
  logic [31:0] cpu_data;
  logic        cpu_stall;
  logic        p0_valid, p1_valid, p2_valid;
  logic [4:0]  p0_reg, p1_reg, p2_reg;
  logic [31:0] p0_data, p1_data, p2_data;
  logic        p0_ready, p1_ready, p2_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        pending;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] rf     [32];
  int          wr_cnt [32];

  regfile_write_arbiter dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .cpu_we(cpu_we), .cpu_reg(cpu_reg), .cpu_data(cpu_data), .cpu_stall(cpu_stall),
    .p0_valid(p0_valid), .p0_reg(p0_reg), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_reg(p1_reg), .p1_data(p1_data), .p1_ready(p1_ready),
    .p2_valid(p2_valid), .p2_reg(p2_reg), .p2_data(p2_data), .p2_ready(p2_ready),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .pending(pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        cw;
    logic [4:0]  cr;
    logic [31:0] cd;
    logic [2:0]  pv;
    logic [4:0]  pr [3];
    logic [31:0] pd [3];
    logic        ew;
    logic [4:0]  er;
    logic [31:0] ed;
    logic [2:0]  erdy;
    logic        epend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic cw, input logic [4:0] cr, input logic [31:0] cd,
                              input logic [2:0] pv,
                              input logic [4:0] r0, input logic [31:0] d0,
                              input logic [4:0] r1, input logic [31:0] d1,
                              input logic [4:0] r2, input logic [31:0] d2,
                              input logic ew, input logic [4:0] er, input logic [31:0] ed,
                              input logic [2:0] erdy, input logic epend);
    vec_t v;
    v.cw = cw; v.cr = cr; v.cd = cd; v.pv = pv;
    v.pr[0] = r0; v.pd[0] = d0;
    v.pr[1] = r1; v.pd[1] = d1;
    v.pr[2] = r2; v.pd[2] = d2;
    v.ew = ew; v.er = er; v.ed = ed; v.erdy = erdy; v.epend = epend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we = 1'b0; cpu_reg = 5'd0; cpu_data = 32'd0;
    p0_valid = 1'b0; p0_reg = 5'd0; p0_data = 32'd0;
    p1_valid = 1'b0; p1_reg = 5'd0; p1_data = 32'd0;
    p2_valid = 1'b0; p2_reg = 5'd0; p2_data = 32'd0;
  endtask

  task automatic check_out(input string name, input logic ew, input logic [4:0] er,
                           input logic [31:0] ed);
    check({name, "_we"}, 32'(ctrl_writeEnable), 32'(ew));
    if (ew) begin
      check({name, "_reg"}, 32'(ctrl_writeReg), 32'(er));
      check({name, "_data"}, data_writeReg, ed);
    end
  endtask

  // Write-port observer: r0 must never be written, and a shadow regfile records final values.
  always @(negedge clock) begin
    if (ctrl_writeEnable === 1'b1) begin
      check("r0_write_guard", 32'(ctrl_writeReg != 5'd0), 32'd1);
      rf[ctrl_writeReg]     = data_writeReg;
      wr_cnt[ctrl_writeReg] = wr_cnt[ctrl_writeReg] + 1;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i]     = 32'd0;
      wr_cnt[i] = 0;
    end
    idle_inputs();
    ctrl_reset = 1'b1;
    cycle();
    cycle();
    check("rst_we", 32'(ctrl_writeEnable), 32'd0);
    check("rst_reg", 32'(ctrl_writeReg), 32'd0);
    check("rst_data", data_writeReg, 32'd0);
    check("rst_ready", 32'({p2_ready, p1_ready, p0_ready}), 32'h7);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    ctrl_reset = 1'b0;

    // Expected values are the outputs seen just after the edge that consumes the row's inputs.
    //             cw  cr     cd            pv      r0     d0     r1     d1     r2     d2     ew  er     ed            rdy     pend
    vecs.push_back(mk(1, 5'd5,  32'hDEADBEEF, 3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 1, 5'd5,  32'hDEADBEEF, 3'b111, 0));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 0, 5'd0,  32'd0,        3'b111, 0));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b111, 5'd20, 32'd1, 5'd22, 32'd2, 5'd23, 32'd3, 0, 5'd0,  32'd0,        3'b000, 1));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 1, 5'd20, 32'd1,        3'b001, 1));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 1, 5'd22, 32'd2,        3'b011, 1));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 1, 5'd23, 32'd3,        3'b111, 0));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 0, 5'd0,  32'd0,        3'b111, 0));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b001, 5'd0,  32'h55, 5'd0, 32'd0, 5'd0,  32'd0, 0, 5'd0,  32'd0,        3'b111, 0));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 0, 5'd0,  32'd0,        3'b111, 0));
    vecs.push_back(mk(1, 5'd0,  32'h77,       3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 0, 5'd0,  32'd0,        3'b111, 0));
    vecs.push_back(mk(1, 5'd7,  32'h70,       3'b010, 5'd0,  32'd0, 5'd9,  32'h90, 5'd0, 32'd0, 1, 5'd7,  32'h70,       3'b101, 1));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 1, 5'd9,  32'h90,       3'b111, 0));
    vecs.push_back(mk(0, 5'd0,  32'd0,        3'b000, 5'd0,  32'd0, 5'd0,  32'd0, 5'd0,  32'd0, 0, 5'd0,  32'd0,        3'b111, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      cpu_we = vecs[n].cw; cpu_reg = vecs[n].cr; cpu_data = vecs[n].cd;
      p0_valid = vecs[n].pv[0]; p0_reg = vecs[n].pr[0]; p0_data = vecs[n].pd[0];
      p1_valid = vecs[n].pv[1]; p1_reg = vecs[n].pr[1]; p1_data = vecs[n].pd[1];
      p2_valid = vecs[n].pv[2]; p2_reg = vecs[n].pr[2]; p2_data = vecs[n].pd[2];
      cycle();
      check_out($sformatf("vec%0d", n), vecs[n].ew, vecs[n].er, vecs[n].ed);
      check($sformatf("vec%0d_ready", n), 32'({p2_ready, p1_ready, p0_ready}), 32'(vecs[n].erdy));
      check($sformatf("vec%0d_pending", n), 32'(pending), 32'(vecs[n].epend));
      check($sformatf("vec%0d_stall", n), 32'(cpu_stall), 32'd0);
    end
    idle_inputs();

    // Starvation: p1 waits behind a CPU that writes every cycle.
    p1_valid = 1'b1; p1_reg = 5'd25; p1_data = 32'h2525;
    cpu_we = 1'b1; cpu_reg = 5'd3; cpu_data = 32'h300;
    cycle();
    check_out("starve_fill", 1'b1, 5'd3, 32'h300);
    check("starve_p1_ready", 32'(p1_ready), 32'd0);
    p1_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cpu_data = 32'h300 + 32'(k);
      check($sformatf("starve_nostall%0d", k), 32'(cpu_stall), 32'd0);
      cycle();
      check_out($sformatf("starve_cpu%0d", k), 1'b1, 5'd3, 32'h300 + 32'(k));
    end
    check("starve_stall_hi", 32'(cpu_stall), 32'd1);
    cpu_data = 32'h308;
    cycle();
    check_out("starve_p1_issue", 1'b1, 5'd25, 32'h2525);
    check("starve_stall_lo", 32'(cpu_stall), 32'd0);
    check("starve_p1_ready_back", 32'(p1_ready), 32'd1);
    cycle();
    check_out("starve_cpu_retry", 1'b1, 5'd3, 32'h308);
    cpu_we = 1'b0;
    cycle();
    check_out("starve_idle", 1'b0, 5'd0, 32'd0);

    // r0 filtering: a CPU write to r0 must not block the buffered p2 write.
    p2_valid = 1'b1; p2_reg = 5'd28; p2_data = 32'h28;
    cycle();
    check_out("r0_fill", 1'b0, 5'd0, 32'd0);
    check("r0_p2_ready", 32'(p2_ready), 32'd0);
    p2_valid = 1'b0;
    cpu_we = 1'b1; cpu_reg = 5'd0; cpu_data = 32'hBAD;
    cycle();
    check_out("r0_p2_issue", 1'b1, 5'd28, 32'h28);
    check("r0_p2_ready_back", 32'(p2_ready), 32'd1);
    cpu_we = 1'b0;
    cycle();
    check_out("r0_idle", 1'b0, 5'd0, 32'd0);
    check("r0_never_written", 32'(wr_cnt[0]), 32'd0);

    // Same register from CPU and p0: both writes issue, p0's lands last.
    p0_valid = 1'b1; p0_reg = 5'd29; p0_data = 32'hB;
    cycle();
    check_out("same_fill", 1'b0, 5'd0, 32'd0);
    p0_valid = 1'b0;
    cpu_we = 1'b1; cpu_reg = 5'd29; cpu_data = 32'hA;
    cycle();
    check_out("same_cpu_first", 1'b1, 5'd29, 32'hA);
    cpu_we = 1'b0;
    cycle();
    check_out("same_p0_second", 1'b1, 5'd29, 32'hB);
    cycle();
    check_out("same_idle", 1'b0, 5'd0, 32'd0);
    check("same_final_value", rf[29], 32'hB);

    // Reset with every buffer full: nothing buffered may ever reach the port.
    for (int r = 10; r <= 13; r++) wr_cnt[r] = 0;
    p0_valid = 1'b1; p0_reg = 5'd10; p0_data = 32'h10;
    p1_valid = 1'b1; p1_reg = 5'd11; p1_data = 32'h11;
    p2_valid = 1'b1; p2_reg = 5'd12; p2_data = 32'h12;
    cycle();
    check("mid_full_pending", 32'(pending), 32'd1);
    check("mid_full_ready", 32'({p2_ready, p1_ready, p0_ready}), 32'h0);
    idle_inputs();
    ctrl_reset = 1'b1;
    p0_valid = 1'b1; p0_reg = 5'd13; p0_data = 32'h13;
    cycle();
    check("mid_rst_we", 32'(ctrl_writeEnable), 32'd0);
    check("mid_rst_ready", 32'({p2_ready, p1_ready, p0_ready}), 32'h7);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    ctrl_reset = 1'b0;
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("mid_post_we%0d", k), 32'(ctrl_writeEnable), 32'd0);
      check($sformatf("mid_post_pending%0d", k), 32'(pending), 32'd0);
    end
    check("mid_no_drained_writes", 32'(wr_cnt[10] + wr_cnt[11] + wr_cnt[12] + wr_cnt[13]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
